// File: rtl/pdm_decimator.sv
// 2nd-order CIC decimator turning a 1-bit PDM stream into 10-bit unsigned PCM samples.
// Define PDM_DECIMATOR_PEAK_EN to build the decaying peak meter; otherwise peak is tied to 0.
module pdm_decimator #(
    parameter int LOG2_DECIM  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pdm_in,
    output logic [9:0] sample,
    output logic       sample_valid,
    output logic [9:0] peak
);
    localparam int W     = 2 * LOG2_DECIM + 1;
    localparam int SHIFT = 2 * LOG2_DECIM - 10;
    localparam logic [W-1:0] FULL_SCALE_M1 = W'((1 << (2 * LOG2_DECIM)) - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   x;
    logic [W-1:0]           int1_q, int1_d;
    logic [W-1:0]           int2_q, int2_d;
    logic [W-1:0]           dly1_q, dly2_q;
    logic [W-1:0]           comb1, comb2;
    logic [W-1:0]           comb_q;
    logic [W-1:0]           clamped;
    logic [LOG2_DECIM-1:0]  phase_q, phase_d;
    logic                   wrap;
    logic                   pending_q;
    logic                   valid_q;
    logic [9:0]             sample_q;
    logic [9:0]             scaled;

    assign x = sync_q[SYNC_STAGES-1];

    // NOTE: always_comb gives every output a value on every path, so no latch can be inferred.
    always_comb begin
        int1_d  = int1_q + W'(x);
        int2_d  = int2_q + int1_d;
        phase_d = phase_q + LOG2_DECIM'(1);
        wrap    = en && (&phase_q);
        comb1   = int2_d - dly1_q;
        comb2   = comb1 - dly2_q;
    end

    // Full scale (comb = R^2) lands one past the 10-bit range, so clamp before scaling.
    assign clamped = (comb_q > FULL_SCALE_M1) ? FULL_SCALE_M1 : comb_q;
    assign scaled  = 10'(clamped >> SHIFT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            int1_q    <= '0;
            int2_q    <= '0;
            dly1_q    <= '0;
            dly2_q    <= '0;
            comb_q    <= '0;
            phase_q   <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            sample_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_in};
            if (en) begin
                int1_q  <= int1_d;
                int2_q  <= int2_d;
                phase_q <= phase_d;
            end
            if (wrap) begin
                dly1_q <= int2_d;
                dly2_q <= comb1;
                comb_q <= comb2;
            end
            // Output registration is deliberately not gated by en: a scheduled pulse always issues.
            pending_q <= wrap;
            valid_q   <= pending_q;
            if (pending_q) begin
                sample_q <= scaled;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;

`ifdef PDM_DECIMATOR_PEAK_EN
    logic [9:0] peak_q;
    logic [9:0] peak_dec;

    assign peak_dec = (peak_q == 10'd0) ? 10'd0 : peak_q - 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (pending_q) begin
            peak_q <= (scaled > peak_dec) ? scaled : peak_dec;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule
